mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter that shares one single-port data memory between the processor datapath (load/store port) and a peripheral/DMA requester. It grants one request at a time with round-robin tie-breaking, drives the memory for a fixed latency, and returns read data with a one-cycle acknowledge pulse. It sits between the datapath's memory interface and the data RAM, alongside the peripheral block.

## Interface

Parameters:
- `ADDR_W`, default 64, address width.
- `DATA_W`, default 64, data width.
- `MEM_LATENCY`, default 2, memory access cycles; must be ≥ 1.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  request, port 0 (datapath).
- `we0`  in  1  write enable, port 0.
- `addr0`  in  ADDR_W  address, port 0.
- `wdata0`  in  DATA_W  write data, port 0.
- `ack0`  out  1  one-cycle completion pulse, port 0.
- `rdata0`  out  DATA_W  read data, port 0 (registered).
- `req1`, `we1`, `addr1`, `wdata1`, `ack1`, `rdata1`: same as port 0, for port 1 (peripheral).
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid in the last ACCESS cycle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant`  out  1  index of the last granted port.

## Operation

- FSM states: IDLE, ACCESS, DONE.
- **IDLE:**
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port ≠ `grant` (round-robin).
  - On a grant: latch the port's `we`, `addr`, `wdata` and the index into `grant`; load the counter with MEM_LATENCY−1; go to ACCESS.
- **ACCESS:**
  - `mem_en`=1. `mem_we`, `mem_addr`, `mem_wdata` come from the latched values and are stable for the whole state.
  - Counter decrements each cycle.
  - At count 0: for a read, capture `mem_rdata` into the granted port's `rdata`; go to DONE.
- **DONE:**
  - `ack` of the granted port = 1 for exactly one cycle. On a read, `rdata` is valid that cycle.
  - Go to IDLE.
- Requests are ignored in ACCESS and DONE. A pending request on the other port waits.
- `rdataN` holds its last read value until the next read on that port. Writes never change `rdata`.
- `ackN` is never high for the non-granted port. `ack0` and `ack1` are never high together.
- Requester rules:
  - Hold `req` high until `ack` is seen.
  - `req` must be low in the cycle after `ack` unless a new access is intended.
  - `addr`/`we`/`wdata` need only be valid in the cycle the grant is taken.
- Reset (asynchronous, at any time, including mid-ACCESS):
  - State → IDLE, counter 0.
  - All outputs 0, except `grant` = 1 so port 0 wins the first tie.
  - No `ack` is issued for an aborted access; the requester re-issues it.

## Timing

- Request first sampled high in IDLE at edge N:
  - ACCESS occupies cycles N+1 … N+MEM_LATENCY.
  - DONE/`ack` is in cycle N+MEM_LATENCY+1.
  - Total latency is MEM_LATENCY+1 cycles from grant edge to `ack`.
- Back-to-back service: IDLE lasts one cycle between accesses. Throughput is one access per MEM_LATENCY+2 cycles.
- With MEM_LATENCY=1, ACCESS lasts exactly one cycle.
- All outputs are registered or decoded from state/latched registers only. There is no combinational path from `req*` to `mem_*` or `ack*`.

## Structure

- Shared package `cpu_bus_pkg`:
  - State typedef (IDLE, ACCESS, DONE).
  - Default `ADDR_W`/`DATA_W` constants, shared with the datapath and peripheral blocks.
- Sub-module `rr_pick2`: combinational pick of the next grant from (`req0`, `req1`, `grant`), with outputs `valid` and `index`.
- The FSM, latency counter and request latch live in `mem_bus_arbiter`.

## Test plan

All scenarios use MEM_LATENCY=2.
1. Single read, port 0:
   - Stimulus: `req0`=1, `addr0`=0x40, memory returns 0xDEAD_BEEF.
   - Required: `mem_en` high for 2 cycles with `mem_addr`=0x40, `mem_we`=0; `ack0` 3 cycles after the grant edge; `rdata0`=0xDEAD_BEEF; `ack1` stays 0.
2. Write, port 1:
   - Stimulus: `we1`=1, `addr1`=0x8, `wdata1`=0x1234.
   - Required: `mem_we`=1, `mem_wdata`=0x1234 for 2 cycles; `ack1` pulses once; `rdata1` unchanged.
3. Simultaneous requests after reset:
   - Stimulus: `req0`=`req1`=1 held continuously.
   - Required: grant order 0, 1, 0, 1; each `ack` separated by 4 cycles; `grant` toggles.
4. Input change during ACCESS:
   - Stimulus: change `addr0` from 0x40 to 0x80 during ACCESS.
   - Required: `mem_addr` stays 0x40 until DONE.
5. Reset mid-ACCESS:
   - Stimulus: assert `reset` in the first ACCESS cycle.
   - Required: `mem_en`, `busy`, `ack*` go to 0 immediately; no `ack`; after release with `req0` still high, a full access restarts and `ack0` arrives 3 cycles later.
6. Request-hold violation:
   - Stimulus: `req0` kept high for one cycle after `ack0`.
   - Required: a second access to the same address is performed. This is legal arbiter behaviour; the checker flags it as a requester-rule violation.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the datapath, peripheral block and memory arbiter:
// default bus widths and the arbiter FSM state encoding.
package cpu_bus_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester ports, the memory port and arbiter status.
// master = arbiter side, slave = requesters/memory side.
interface mem_bus_arbiter_if
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // Handshake: a requester raises reqN with we/addr/wdata valid and holds reqN
    // until ackN pulses for one cycle; reqN is low the cycle after ackN unless a
    // new access is wanted. rdataN is valid in the ack cycle of a read.
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant;

    modport master (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, grant
    );

    modport slave (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, grant
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic grant,
    output logic valid,
    output logic index
);

    always_comb begin
        valid = req0 | req1;
        index = (req0 & req1) ? ~grant : req1;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port data RAM between the datapath (port 0) and the
// peripheral/DMA requester (port 1), one fixed-latency access at a time.
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.master bus,
    output state_t            dbg_state
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              pick_valid;
    logic              pick_index;
    logic              take_grant;

    logic              mem_en_c;
    logic              mem_we_c;
    logic              ack0_c;
    logic              ack1_c;
    logic              busy_c;

    rr_pick2 u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .grant (grant_q),
        .valid (pick_valid),
        .index (pick_index)
    );

    assign take_grant = (state == IDLE) && pick_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on state and latched request, never on req* directly.
    always_comb begin
        mem_en_c = 1'b0;
        mem_we_c = 1'b0;
        ack0_c   = 1'b0;
        ack1_c   = 1'b0;
        busy_c   = (state != IDLE);
        case (state)
            ACCESS: begin
                mem_en_c = 1'b1;
                mem_we_c = we_q;
            end
            DONE: begin
                ack0_c = ~grant_q;
                ack1_c = grant_q;
            end
            default: ;
        endcase
    end

    // grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            grant_q  <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (take_grant) begin
            grant_q <= pick_index;
            cnt     <= CNT_W'(MEM_LATENCY - 1);
            if (pick_index) begin
                we_q    <= bus.we1;
                addr_q  <= bus.addr1;
                wdata_q <= bus.wdata1;
            end else begin
                we_q    <= bus.we0;
                addr_q  <= bus.addr0;
                wdata_q <= bus.wdata0;
            end
        end else if (state == ACCESS) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!we_q) begin
                if (grant_q) rdata1_q <= bus.mem_rdata;
                else         rdata0_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ack0      = ack0_c;
    assign bus.ack1      = ack1_c;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = busy_c;
    assign bus.grant     = grant_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    import cpu_bus_pkg::*;

    localparam int L  = 2;
    localparam int AW = 64;
    localparam int DW = 64;

    // ---------------- clock / reset ----------------
    logic   clock = 1'b0;
    logic   reset;
    state_t dbg_state;
    logic   chk_on = 1'b0;

    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int viol0   = 0;
    int viol1   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [DW-1:0] env_ram[16];
    logic [DW-1:0] ref_ram[16];

    assign bus.mem_rdata = env_ram[bus.mem_addr[6:3]];

    always @(posedge clock) begin
        if (!reset && bus.mem_en && bus.mem_we) env_ram[bus.mem_addr[6:3]] = bus.mem_wdata;
    end

    // ---------------- behavioural model ----------------
    // Each access is a timeline: L cycles driving memory, then one ack cycle,
    // then at least one idle cycle in which the next request can be taken.
    typedef struct {
        state_t        st;
        logic          busy, en, we, ack0, ack1, gnt, commit;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, r0, r1;
    } exp_t;

    exp_t          cur;
    exp_t          exp_q[$];
    logic          m_last;
    logic [DW-1:0] m_r0, m_r1;

    function automatic exp_t idle_rec();
        exp_t e;
        e.st = IDLE; e.busy = 1'b0; e.en = 1'b0; e.we = 1'b0;
        e.ack0 = 1'b0; e.ack1 = 1'b0; e.gnt = m_last; e.commit = 1'b0;
        e.addr = '0; e.wdata = '0; e.r0 = m_r0; e.r1 = m_r1;
        return e;
    endfunction

    task automatic model_grant();
        exp_t          e;
        logic          p, w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        p  = (bus.req0 && bus.req1) ? ~m_last : bus.req1;
        w  = p ? bus.we1 : bus.we0;
        a  = p ? bus.addr1 : bus.addr0;
        wd = p ? bus.wdata1 : bus.wdata0;
        for (int i = 0; i < L; i++) begin
            e = idle_rec();
            e.st = ACCESS; e.busy = 1'b1; e.en = 1'b1; e.we = w;
            e.addr = a; e.wdata = wd; e.gnt = p;
            exp_q.push_back(e);
        end
        if (!w) begin
            if (p) m_r1 = ref_ram[a[6:3]];
            else   m_r0 = ref_ram[a[6:3]];
        end
        m_last = p;
        e = idle_rec();
        e.st = DONE; e.busy = 1'b1; e.ack0 = ~p; e.ack1 = p;
        e.commit = w; e.addr = a; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_last = 1'b1;
            m_r0   = '0;
            m_r1   = '0;
            cur    = idle_rec();
        end else begin
            if (cur.commit) ref_ram[cur.addr[6:3]] = cur.wdata;
            if (cur.st == IDLE && (bus.req0 || bus.req1)) model_grant();
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = idle_rec();
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (chk_on) begin
            chk("state",  64'(dbg_state),  64'(cur.st));
            chk("busy",   64'(bus.busy),   64'(cur.busy));
            chk("mem_en", 64'(bus.mem_en), 64'(cur.en));
            if (cur.en) begin
                chk("mem_we",    64'(bus.mem_we), 64'(cur.we));
                chk("mem_addr",  bus.mem_addr,    cur.addr);
                chk("mem_wdata", bus.mem_wdata,   cur.wdata);
            end
            chk("ack0",   64'(bus.ack0),  64'(cur.ack0));
            chk("ack1",   64'(bus.ack1),  64'(cur.ack1));
            chk("rdata0", bus.rdata0,     cur.r0);
            chk("rdata1", bus.rdata1,     cur.r1);
            chk("grant",  64'(bus.grant), 64'(cur.gnt));
        end
    end

    // ---------------- requester-rule monitor ----------------
    logic a0_cur = 1'b0, a1_cur = 1'b0, a0_prev = 1'b0, a1_prev = 1'b0;

    always @(negedge clock) begin
        a0_cur = bus.ack0;
        a1_cur = bus.ack1;
    end

    always @(posedge clock) begin
        if (!reset) begin
            if (a0_prev && bus.req0) begin
                viol0++;
                $display("[TB] requester rule: req0 still high in the cycle after ack0 (t=%0t)", $time);
            end
            if (a1_prev && bus.req1) begin
                viol1++;
                $display("[TB] requester rule: req1 still high in the cycle after ack1 (t=%0t)", $time);
            end
        end
        a0_prev = a0_cur;
        a1_prev = a1_cur;
    end

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = wd;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = wd;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // One access on port p; addr switches to a2 after the first ACCESS cycle.
    task automatic do_access(input int p, input logic w, input logic [AW-1:0] a,
                             input logic [AW-1:0] a2, input logic [DW-1:0] wd,
                             output int lat, output int en_cnt, output int other_ack);
        logic ack_p;
        lat = 0; en_cnt = 0; other_ack = 0;
        @(negedge clock);
        set_port(p, 1'b1, w, a, wd);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (bus.mem_en) begin
                en_cnt++;
                chk("t_mem_addr", bus.mem_addr, a);
                chk("t_mem_we", 64'(bus.mem_we), 64'(w));
                if (w) chk("t_mem_wdata", bus.mem_wdata, wd);
                if (en_cnt == 1) set_port(p, 1'b1, w, a2, wd);
            end
            ack_p = (p == 0) ? bus.ack0 : bus.ack1;
            if (((p == 0) ? bus.ack1 : bus.ack0) == 1'b1) other_ack++;
            if (ack_p) begin
                lat = k;
                break;
            end
        end
        set_port(p, 1'b0, w, a2, wd);
        chk("t_ack_latency", 64'(lat), 64'(L + 1));
        chk("t_other_ack", 64'(other_ack), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    int lat, en_cnt, oth, v0_before;
    int order[4];
    int ack_at[4];
    int n_ack;
    logic cool0, cool1;

    initial begin
        reset = 1'b1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 16; i++) begin
            env_ram[i] = {$urandom, $urandom};
            ref_ram[i] = env_ram[i];
        end
        env_ram[8] = 64'hDEAD_BEEF;
        ref_ram[8] = 64'hDEAD_BEEF;
        repeat (2) @(negedge clock);
        chk_on = 1'b1;
        chk("reset_grant",  64'(bus.grant),  64'd1);
        chk("reset_busy",   64'(bus.busy),   64'd0);
        chk("reset_mem_en", 64'(bus.mem_en), 64'd0);
        chk("reset_rdata0", bus.rdata0,      64'd0);
        reset = 1'b0;

        // Single read on port 0.
        do_access(0, 1'b0, 64'h40, 64'h40, 64'h0, lat, en_cnt, oth);
        chk("t1_en_cycles", 64'(en_cnt), 64'd2);
        chk("t1_rdata0", bus.rdata0, 64'hDEAD_BEEF);

        // Write on port 1; rdata1 must keep its reset value.
        do_access(1, 1'b1, 64'h8, 64'h8, 64'h1234, lat, en_cnt, oth);
        chk("t2_en_cycles", 64'(en_cnt), 64'd2);
        chk("t2_rdata1", bus.rdata1, 64'd0);

        // Both ports requesting continuously after reset.
        do_reset();
        @(negedge clock);
        set_port(0, 1'b1, 1'b0, 64'h10, '0);
        set_port(1, 1'b1, 1'b0, 64'h18, '0);
        n_ack = 0;
        for (int k = 1; k <= 40 && n_ack < 4; k++) begin
            @(negedge clock);
            if (bus.ack0 || bus.ack1) begin
                order[n_ack]  = bus.ack1 ? 1 : 0;
                ack_at[n_ack] = k;
                n_ack++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("t3_ack_count", 64'(n_ack), 64'd4);
        for (int i = 0; i < 4; i++) chk("t3_order", 64'(order[i]), 64'(i % 2));
        for (int i = 1; i < 4; i++) chk("t3_ack_gap", 64'(ack_at[i] - ack_at[i-1]), 64'(L + 2));
        chk("t3_rdata0", bus.rdata0, ref_ram[2]);
        chk("t3_rdata1", bus.rdata1, ref_ram[3]);

        // Address changes while ACCESS is in progress.
        do_access(0, 1'b0, 64'h40, 64'h80, 64'h0, lat, en_cnt, oth);
        chk("t4_rdata0", bus.rdata0, 64'hDEAD_BEEF);

        // Reset in the first ACCESS cycle, request kept high across it.
        @(negedge clock);
        set_port(0, 1'b1, 1'b0, 64'h40, '0);
        @(negedge clock);
        chk("t5_in_access", 64'(bus.mem_en), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_mem_en", 64'(bus.mem_en), 64'd0);
        chk("t5_busy",   64'(bus.busy),   64'd0);
        chk("t5_ack0",   64'(bus.ack0),   64'd0);
        chk("t5_grant",  64'(bus.grant),  64'd1);
        @(negedge clock);
        reset = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (bus.ack0) begin
                lat = k;
                break;
            end
        end
        bus.req0 = 1'b0;
        chk("t5_restart_latency", 64'(lat), 64'(L + 1));
        chk("t5_rdata0", bus.rdata0, 64'hDEAD_BEEF);

        // req0 held for the cycle after ack0: a second access follows.
        repeat (2) @(negedge clock);
        v0_before = viol0;
        set_port(0, 1'b1, 1'b0, 64'h40, '0);
        n_ack = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (bus.ack0) begin
                n_ack++;
                if (n_ack == 2) break;
            end else if (n_ack == 1 && bus.mem_en) begin
                bus.req0 = 1'b0;
            end
        end
        bus.req0 = 1'b0;
        chk("t6_acks", 64'(n_ack), 64'd2);
        chk("t6_violation_seen", 64'(viol0 - v0_before), 64'd1);

        // Random traffic from both requesters.
        repeat (3) @(negedge clock);
        v0_before = viol0 + viol1;
        cool0 = 1'b0;
        cool1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (bus.req0 && bus.ack0) begin
                bus.req0 = 1'b0; cool0 = 1'b1;
            end else if (!bus.req0 && !cool0 && $urandom_range(0, 3) == 0) begin
                bus.req0 = 1'b1;
            end else begin
                cool0 = 1'b0;
            end
            if (bus.req1 && bus.ack1) begin
                bus.req1 = 1'b0; cool1 = 1'b1;
            end else if (!bus.req1 && !cool1 && $urandom_range(0, 3) == 0) begin
                bus.req1 = 1'b1;
            end else begin
                cool1 = 1'b0;
            end
            bus.we0    = ($urandom_range(0, 2) == 0);
            bus.addr0  = {$urandom, $urandom};
            bus.wdata0 = {$urandom, $urandom};
            bus.we1    = ($urandom_range(0, 2) == 0);
            bus.addr1  = {$urandom, $urandom};
            bus.wdata1 = {$urandom, $urandom};
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (L + 4) @(negedge clock);
        chk("rand_no_rule_violation", 64'(viol0 + viol1), 64'(v0_before));
        chk("rand_idle_at_end", 64'(bus.busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
